// File: rtl/receiver_uart.sv
// rtl/receiver_uart.sv - 8N1 UART receiver with mid-bit sampling, 4-entry receive FIFO and sticky error flags
module receiver_uart #(
   parameter int clk_freq_hz = 12000000,
   parameter int baud_rate   = 115200
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_uart_rx,
   input  logic       i_pop,
   input  logic       i_clr_err,
   output logic [7:0] o_data,
   output logic       o_valid,
   output logic [2:0] o_level,
   output logic       o_frame_err,
   output logic       o_overrun
);

   localparam int DIV  = clk_freq_hz / baud_rate;
   localparam int HALF = DIV / 2;
   localparam int CW   = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] C_DIV_END  = CW'(DIV - 1);
   localparam logic [CW-1:0] C_HALF_END = CW'(HALF - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_WAIT_HIGH
   } state_t;

   logic          r_rx_meta;
   logic          r_rx_s;
   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic [2:0]    r_bit;
   logic [7:0]    r_shift;

   logic [7:0]    r_mem [4];
   logic [1:0]    r_wptr;
   logic [1:0]    r_rptr;
   logic [2:0]    r_level;
   logic          r_frame_err;
   logic          r_overrun;

   logic          w_stop_tick;
   logic          w_push;
   logic          w_frame_set;
   logic          w_pop;
   logic          w_full;
   logic          w_accept;
   logic          w_drop;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rx_meta <= 1'b1;
         r_rx_s    <= 1'b1;
      end else begin
         r_rx_meta <= i_uart_rx;
         r_rx_s    <= r_rx_meta;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_bit   <= '0;
         r_shift <= '0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (!r_rx_s) begin
                  r_state <= S_START;
                  r_cnt   <= '0;
               end
            end
            // Recheck the line at the middle of the start bit to reject glitches
            S_START: begin
               if (r_cnt == C_HALF_END) begin
                  r_cnt <= '0;
                  r_bit <= '0;
                  r_state <= r_rx_s ? S_IDLE : S_DATA;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            S_DATA: begin
               if (r_cnt == C_DIV_END) begin
                  r_cnt   <= '0;
                  r_shift <= {r_rx_s, r_shift[7:1]};
                  r_bit   <= r_bit + 3'd1;
                  if (r_bit == 3'd7) begin
                     r_state <= S_STOP;
                  end
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            S_STOP: begin
               if (r_cnt == C_DIV_END) begin
                  r_cnt   <= '0;
                  r_state <= r_rx_s ? S_IDLE : S_WAIT_HIGH;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            S_WAIT_HIGH: begin
               if (r_rx_s) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign w_stop_tick = (r_state == S_STOP) && (r_cnt == C_DIV_END);
   assign w_push      = w_stop_tick && r_rx_s;
   assign w_frame_set = w_stop_tick && !r_rx_s;

   assign w_pop    = i_pop && (r_level != 3'd0);
   assign w_full   = (r_level == 3'd4);
   assign w_accept = w_push && (!w_full || w_pop);
   assign w_drop   = w_push && w_full && !w_pop;

   // A flag raised in the same cycle as a clear request wins over the clear
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < 4; i++) begin
            r_mem[i] <= '0;
         end
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_level     <= '0;
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         if (w_accept) begin
            r_mem[r_wptr] <= r_shift;
            r_wptr        <= r_wptr + 2'd1;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + 2'd1;
         end
         r_level <= r_level + 3'(w_accept) - 3'(w_pop);

         if (w_frame_set) begin
            r_frame_err <= 1'b1;
         end else if (i_clr_err) begin
            r_frame_err <= 1'b0;
         end

         if (w_drop) begin
            r_overrun <= 1'b1;
         end else if (i_clr_err) begin
            r_overrun <= 1'b0;
         end
      end
   end

   assign o_data      = r_mem[r_rptr];
   assign o_valid     = (r_level != 3'd0);
   assign o_level     = r_level;
   assign o_frame_err = r_frame_err;
   assign o_overrun   = r_overrun;

endmodule

// File: doc/receiver_uart.md
RECEIVER_UART -- requirements
Module: receiver_uart

Interface
REQ-001 The block SHALL have parameter clk_freq_hz, default 12000000: input clock frequency in Hz.
REQ-002 The block SHALL have parameter baud_rate, default 115200: serial bit rate.
REQ-003 The block SHALL have port i_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port i_rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port i_uart_rx, input, 1 bit: asynchronous serial line, idle high.
REQ-006 The block SHALL have port i_pop, input, 1 bit: consumer takes the head byte this cycle.
REQ-007 The block SHALL have port i_clr_err, input, 1 bit: clears the sticky error flags.
REQ-008 The block SHALL have port o_data, output, 8 bits: head byte of the receive FIFO.
REQ-009 The block SHALL have port o_valid, output, 1 bit: FIFO non-empty.
REQ-010 The block SHALL have port o_level, output, 3 bits: FIFO occupancy, 0..4.
REQ-011 The block SHALL have port o_frame_err, output, 1 bit: sticky framing error.
REQ-012 The block SHALL have port o_overrun, output, 1 bit: sticky overrun.

Function
REQ-013 The block SHALL use DIV = clk_freq_hz / baud_rate with integer truncation (104 at defaults) and HALF = DIV / 2 (52).
REQ-014 The block SHALL pass i_uart_rx through a 2-flop synchronizer; all decisions SHALL use the second flop (rx_s).
REQ-015 The FSM SHALL have states IDLE, START, DATA, STOP and WAIT_HIGH.
- IDLE: rx_s = 0 -> START, with the counter cleared.
REQ-016 In START, at counter = HALF-1, the FSM SHALL go to DATA (counter and bit index cleared) if rx_s = 0, else return to IDLE as a glitch, with no flag set.
REQ-017 In DATA, at counter = DIV-1, the FSM SHALL shift rx_s in LSB first and clear the counter; after the 8th bit it SHALL go to STOP.
REQ-018 In STOP, at counter = DIV-1, the FSM SHALL do the following:
- rx_s = 1: push the byte and go to IDLE.
- rx_s = 0: discard the byte, set o_frame_err, and go to WAIT_HIGH.
REQ-019 WAIT_HIGH SHALL go to IDLE on the first cycle with rx_s = 1, so that a break condition produces exactly one framing error.
REQ-020 The FIFO SHALL be 4 entries, first-in first-out, with pointers wrapping modulo 4.
- o_data: the head entry.
- o_valid: o_level != 0.
REQ-021 A pushed byte SHALL appear on o_valid/o_data in the cycle after the stop-bit sample.
REQ-022 i_pop with o_valid = 1 SHALL remove the head at that edge; i_pop with o_valid = 0 SHALL be ignored.
REQ-023 A push when o_level = 4 and no pop in the same cycle SHALL drop the new byte, leave the FIFO unchanged, and set o_overrun.
REQ-024 A push and a pop in the same cycle SHALL both take effect, including when full, with o_level unchanged and no overrun.
REQ-025 When i_clr_err is asserted, the block SHALL clear o_frame_err and o_overrun, except that a flag being set in the same cycle SHALL stay set.
REQ-026 The block SHALL keep FIFO contents and occupancy unaffected by i_clr_err.
REQ-027 The block SHALL keep o_data stable whenever o_valid = 0 and no push occurs.

Reset
REQ-028 The block SHALL, while i_rst = 1, set the synchronizer flops to 1 and the FSM to IDLE.
REQ-029 The block SHALL, while i_rst = 1, clear the counters, bit index and FIFO pointers.
REQ-030 The block SHALL, while i_rst = 1, hold o_valid = 0, o_level = 0, o_frame_err = 0, o_overrun = 0 and o_data = 0x00.
REQ-031 On reset mid-frame, the block SHALL abandon the partial byte, and SHALL never push it or flag it.
REQ-032 After reset release, the block SHALL resume in IDLE: a line already low re-enters START and is treated as a new start bit.

Verification
REQ-033 The bench SHALL send 0xA5 at 115200 baud with defaults -> o_valid rises 1 cycle after the stop sample, o_data = 0xA5, o_level = 1, and i_pop returns o_level to 0.
REQ-034 The bench SHALL send 0x00, 0xFF, 0x55, 0x3C without popping -> o_level = 4, and sequential pops yield the same order.
REQ-035 The bench SHALL then send a fifth byte 0x77 -> o_overrun = 1 and the FIFO is still 0x00, 0xFF, 0x55, 0x3C.
- Repeat with i_pop asserted on the push cycle -> no overrun, and 0x77 ends as the tail.
REQ-036 The bench SHALL drive a 20-cycle low glitch on an idle line -> no push and no flags; the FSM is back in IDLE by cycle 55.
REQ-037 The bench SHALL send a frame with the stop bit 0, then hold the line low for 3 bit times -> exactly one o_frame_err and no push.
- Then pulse i_clr_err -> flag cleared.
REQ-038 The bench SHALL assert i_rst in the 4th data bit of 0xC3, release it, and send 0x81 -> only 0x81 is received, with no flags.
